// File: rtl/sort_seq_ctrl.sv
// Sequencer for an odd-even transposition chain of sort_pe cells: loads one beat per cell, then runs NUM_PE compare/exchange phases.
// Latency: NUM_PE*(SORT_LAT+2) cycles from the cycle after the last load beat to the done pulse; busy is high from start to done.
// Backpressure: in_ready is high only in LOAD and LOAD waits indefinitely for in_valid; optional cycle counter under SORT_CYCLE_CNT_EN.
module sort_seq_ctrl #(
    parameter int NUM_PE   = 4,
    parameter int DATA_W   = 32,
    parameter int SORT_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_data,
    output logic [NUM_PE-1:0]   write_enable,
    output logic [DATA_W-1:0]   write_data1,
    output logic [DATA_W-1:0]   write_data2,
    output logic                sort_en,
    output logic [NUM_PE-1:0]   receive_right,
    output logic [NUM_PE-1:0]   send_right,
    output logic [NUM_PE-1:0]   receive_left,
    output logic [NUM_PE-1:0]   send_left,
    output logic                busy,
    output logic                done,
    output logic [15:0]         cycle_cnt
);

    localparam int PW = (NUM_PE > 2) ? $clog2(NUM_PE) : 1;
    localparam int WW = (SORT_LAT > 2) ? $clog2(SORT_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        SORT  = 3'd3,
        WAIT  = 3'd4,
        XFER  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t          state;
    logic [PW-1:0]   load_idx;
    logic [PW-1:0]   p;
    logic [WW-1:0]   wait_cnt;
    logic            beat;

    // Left cells of a phase share the phase parity; the last cell never leads a pair.
    function automatic logic [NUM_PE-1:0] left_mask(input logic par);
        logic [NUM_PE-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_PE - 1; i++) begin
            m[i] = (((i % 2) == 1) == par);
        end
        return m;
    endfunction

    assign beat         = in_valid && in_ready;
    assign write_enable = beat ? (NUM_PE'(1) << load_idx) : '0;
    assign write_data1  = in_data[DATA_W-1:0];
    assign write_data2  = in_data[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            load_idx      <= '0;
            p             <= '0;
            wait_cnt      <= '0;
            in_ready      <= 1'b0;
            sort_en       <= 1'b0;
            receive_right <= '0;
            send_right    <= '0;
            receive_left  <= '0;
            send_left     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        load_idx <= '0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (load_idx == PW'(NUM_PE - 1)) begin
                            state         <= FETCH;
                            in_ready      <= 1'b0;
                            p             <= '0;
                            receive_right <= left_mask(1'b0);
                        end else begin
                            load_idx <= load_idx + 1'b1;
                        end
                    end
                end
                FETCH: begin
                    receive_right <= '0;
                    sort_en       <= 1'b1;
                    state         <= SORT;
                end
                SORT: begin
                    sort_en <= 1'b0;
                    if (SORT_LAT == 1) begin
                        state        <= XFER;
                        send_right   <= left_mask(p[0]);
                        receive_left <= left_mask(p[0]) << 1;
                        send_left    <= left_mask(p[0]) << 1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    // Leave WAIT so that XFER lines up with sort_finish in the cells.
                    if (wait_cnt == WW'(SORT_LAT - 2)) begin
                        state        <= XFER;
                        wait_cnt     <= '0;
                        send_right   <= left_mask(p[0]);
                        receive_left <= left_mask(p[0]) << 1;
                        send_left    <= left_mask(p[0]) << 1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                XFER: begin
                    send_right   <= '0;
                    receive_left <= '0;
                    send_left    <= '0;
                    if (p == PW'(NUM_PE - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        p             <= p + 1'b1;
                        state         <= FETCH;
                        receive_right <= left_mask(~p[0]);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SORT_CYCLE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state == IDLE && start) begin
            cnt_q <= '0;
        end else if (busy && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl (NUM_PE=4, SORT_LAT=2) with a behavioural sort_pe chain model.
module tb_sort_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [3:0]  write_enable;
    logic [31:0] write_data1;
    logic [31:0] write_data2;
    logic        sort_en;
    logic [3:0]  receive_right;
    logic [3:0]  send_right;
    logic [3:0]  receive_left;
    logic [3:0]  send_left;
    logic        busy;
    logic        done;
    logic [15:0] cycle_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    int cell_a [4];
    int cell_b [4];

    sort_seq_ctrl #(.NUM_PE(4), .DATA_W(32), .SORT_LAT(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .write_enable  (write_enable),
        .write_data1   (write_data1),
        .write_data2   (write_data2),
        .sort_en       (sort_en),
        .receive_right (receive_right),
        .send_right    (send_right),
        .receive_left  (receive_left),
        .send_left     (send_left),
        .busy          (busy),
        .done          (done),
        .cycle_cnt     (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sort_pe chain model: load on write_enable, local sort on sort_en, merge-split on a full exchange.
    always @(posedge clk) begin
        int v [4];
        int t;
        for (int i = 0; i < 4; i++) begin
            if (write_enable[i]) begin
                cell_a[i] = int'(write_data1);
                cell_b[i] = int'(write_data2);
            end
        end
        if (sort_en) begin
            for (int i = 0; i < 4; i++) begin
                if (cell_a[i] > cell_b[i]) begin
                    t = cell_a[i]; cell_a[i] = cell_b[i]; cell_b[i] = t;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (send_right[i] && receive_left[i+1] && send_left[i+1]) begin
                v[0] = cell_a[i]; v[1] = cell_b[i]; v[2] = cell_a[i+1]; v[3] = cell_b[i+1];
                for (int x = 0; x < 3; x++)
                    for (int y = 0; y < 3 - x; y++)
                        if (v[y] > v[y+1]) begin
                            t = v[y]; v[y] = v[y+1]; v[y+1] = t;
                        end
                cell_a[i] = v[0]; cell_b[i] = v[1]; cell_a[i+1] = v[2]; cell_b[i+1] = v[3];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] outs();
        return {receive_right, send_right, receive_left, send_left, write_enable,
                sort_en, in_ready, busy, done, cycle_cnt == 16'd0};
    endfunction

    // Expected outputs k cycles after the last load beat (k=17 is DONE, k=18 back in IDLE).
    function automatic logic [24:0] exp_outs(input int k);
        int ph, pos;
        logic [3:0] lm, rm;
        logic [3:0] rr, sr, rl;
        logic se, bz, dn;
        ph  = (k - 1) / 4;
        pos = (k - 1) % 4;
        lm  = (ph % 2 == 0) ? 4'b0101 : 4'b0010;
        rm  = (ph % 2 == 0) ? 4'b1010 : 4'b0100;
        rr = 4'b0; sr = 4'b0; rl = 4'b0; se = 1'b0; bz = 1'b1; dn = 1'b0;
        if (k <= 16) begin
            if (pos == 0) rr = lm;
            if (pos == 1) se = 1'b1;
            if (pos == 3) begin sr = lm; rl = rm; end
        end else if (k == 17) begin
            dn = 1'b1;
        end else begin
            bz = 1'b0;
        end
`ifdef SORT_CYCLE_CNT_EN
        return {rr, sr, rl, rl, 4'b0, se, 1'b0, bz, dn, 1'b0};
`else
        return {rr, sr, rl, rl, 4'b0, se, 1'b0, bz, dn, 1'b1};
`endif
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives one beat in the current cycle, checks its strobe, ends at the next negedge.
    task automatic beat(input int idx, input int first, input int second, input int gap);
        in_valid = 1'b1;
        in_data  = {32'(second), 32'(first)};
        #1;
        check($sformatf("we_beat%0d", idx), 64'(write_enable), 64'(4'b0001 << idx));
        @(negedge clk);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            #1;
            check($sformatf("we_gap%0d_%0d", idx, g), 64'({write_enable, in_ready}), 64'({4'b0000, 1'b1}));
            @(negedge clk);
        end
    endtask

    // Called in cycle t+1; checks cycles t+1..t+kmax; optional start pulse in phase-1 SORT.
    task automatic run_phases(input int kmax, input bit poke_start);
        for (int k = 1; k <= kmax; k++) begin
            #1;
            check($sformatf("phase_k%0d", k), 64'(outs()), 64'(exp_outs(k)));
            if (k == kmax) break;
            start = (poke_start && k == 6);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic check_sorted(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_cell%0d", tag, i), {32'(cell_b[i]), 32'(cell_a[i])},
                  {32'(2 * i + 2), 32'(2 * i + 1)});
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        check("reset_outs", 64'(outs()), 64'({24'b0, 1'b1}));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", 64'(outs()), 64'({24'b0, 1'b1}));

        // Back-to-back load, start pulsed during phase-1 SORT must be ignored.
        do_start();
        check("load_ready_busy", 64'({in_ready, busy}), 64'(2'b11));
        in_data = {32'd8, 32'd7};
        #1;
        check("write_data", {write_data2, write_data1}, {32'd8, 32'd7});
        beat(0, 7, 8, 0);
        beat(1, 5, 6, 0);
        beat(2, 3, 4, 0);
        beat(3, 1, 2, 0);
        run_phases(18, 1'b1);
        check_sorted("b2b");
`ifdef SORT_CYCLE_CNT_EN
        check("cycle_cnt", 64'(cycle_cnt), 64'd21);
        @(negedge clk);
        check("cycle_cnt_hold", 64'(cycle_cnt), 64'd21);
`else
        check("cycle_cnt", 64'(cycle_cnt), 64'd0);
        @(negedge clk);
`endif
        check("idle_after", 64'({busy, in_ready}), 64'(0));

        // Gapped load: three idle cycles between beats.
        do_start();
        beat(0, 2, 1, 3);
        beat(1, 8, 7, 3);
        beat(2, 4, 3, 3);
        beat(3, 6, 5, 0);
        run_phases(18, 1'b0);
        check_sorted("gap");
        @(negedge clk);

        // Reset during phase-2 WAIT.
        do_start();
        beat(0, 7, 8, 0);
        beat(1, 5, 6, 0);
        beat(2, 3, 4, 0);
        beat(3, 1, 2, 0);
        run_phases(11, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_outs", 64'(outs()), 64'({24'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("abort_quiet%0d", c), 64'({done, busy}), 64'(0));
        end

        // Fresh run after the abort.
        do_start();
        beat(0, 4, 3, 0);
        beat(1, 8, 7, 1);
        beat(2, 1, 2, 0);
        beat(3, 6, 5, 0);
        run_phases(18, 1'b0);
        check_sorted("post_abort");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
